rect_fill_engine: RTL and testbench

- Hardware rectangle rasteriser.
- Replaces the software draw-square loop (one VGA instruction, an INC and a BLE per pixel) with a dedicated pixel generator.
- Accepts a rectangle descriptor from the CPU and streams pixel writes into video RAM at up to one pixel per clock.
- Supports fill, outline and checker modes, screen clipping, coordinate reordering, backpressure and abort.

---
 rtl/rect_fill_engine_if.sv | 23 ++
 rtl/rect_fill_engine.sv | 84 ++++++++
 tb/tb_rect_fill_engine.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rect_fill_engine_if.sv
// rect_fill_engine_if: command, RAM-write and status signals of the rectangle fill engine
interface rect_fill_engine_if #(
  parameter int COORD_W = 16,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 16
);
  logic               start, abort;
  logic [COORD_W-1:0] xi, yi, xf, yf;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] color0, color1;
  logic               wr_ready, wr_enable;
  logic [ADDR_W-1:0]  wr_address;
  logic [COLOR_W-1:0] wr_data;
  logic               busy, done;
  modport master (
    output start, abort, xi, yi, xf, yf, mode, color0, color1, wr_ready,
    input  wr_enable, wr_address, wr_data, busy, done
  );
  modport slave (
    input  start, abort, xi, yi, xf, yf, mode, color0, color1, wr_ready,
    output wr_enable, wr_address, wr_data, busy, done
  );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rectangle rasteriser streaming clipped fill/outline/checker pixel writes into video RAM
module rect_fill_engine #(
  parameter int COORD_W = 16,
  parameter int COLOR_W = 3,
  parameter int H_RES   = 80,
  parameter int V_RES   = 60,
  parameter int ADDR_W  = 16
) (
  input logic clk,
  input logic rst,
  rect_fill_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  state_t state, state_n;
  logic [COORD_W-1:0] xi, yi, xf, yf, xl, xr, yt, yb, x, y;
  logic [COORD_W-1:0] mx, my, cxl, cxr, cyt, cyb, nx, ny, px, py;
  logic [1:0] mode;
  logic [COLOR_W-1:0] c0, c1, data;
  logic [ADDR_W-1:0] addr;
  logic off, last, full_row, step;
  always_comb begin
    cxl = xi < xf ? xi : xf;
    mx = xi < xf ? xf : xi;
    cyt = yi < yf ? yi : yf;
    my = yi < yf ? yf : yi;
    cxr = mx > XMAX ? XMAX : mx;
    cyb = my > YMAX ? YMAX : my;
    off = cxl > XMAX || cyt > YMAX;
    last = x == xr && y == yb;
    full_row = mode != 2'd1 || y == yt || y == yb;
    // outline interior rows jump straight from the left edge to the right edge
    nx = x == xr ? xl : full_row ? x + ONE : xr;
    ny = x == xr ? y + ONE : y;
    px = state == CLIP ? cxl : nx;
    py = state == CLIP ? cyt : ny;
    step = state == CLIP || (state == DRAW && bus.wr_ready);
    state_n = state == IDLE ? (bus.start ? CLIP : IDLE) :
              state == CLIP ? (bus.abort || off ? DONE : DRAW) :
              state == DRAW ? (bus.abort || (bus.wr_ready && last) ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      {xi, yi, xf, yf, xl, xr, yt, yb, x, y} <= '0;
      mode <= '0;
      c0 <= '0;
      c1 <= '0;
      addr <= '0;
      data <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        xi <= bus.xi;
        yi <= bus.yi;
        xf <= bus.xf;
        yf <= bus.yf;
        mode <= bus.mode;
        c0 <= bus.color0;
        c1 <= bus.color1;
      end
      if (state == CLIP) begin
        xl <= cxl;
        xr <= cxr;
        yt <= cyt;
        yb <= cyb;
      end
      // address and colour are registered together with the coordinate they describe
      if (step) begin
        x <= px;
        y <= py;
        addr <= ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
        data <= mode == 2'd2 && (px[0] ^ py[0]) ? c1 : c0;
      end
    end
  assign bus.wr_enable = state == DRAW;
  assign bus.wr_address = addr;
  assign bus.wr_data = data;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: scoreboard bench comparing DUT pixel writes against a geometric reference model
module tb_rect_fill_engine;
  typedef struct {int addr; int data;} pix_t;
  logic clk, rst;
  int n_cmp, n_err, rdy_mode;
  pix_t sb[$], ref_px[$];
  rect_fill_engine_if bus ();
  rect_fill_engine dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic build(input int xi, yi, xf, yf, md, c0, c1);
    int xl, xr, yt, yb;
    ref_px.delete();
    xl = xi < xf ? xi : xf;
    xr = xi < xf ? xf : xi;
    yt = yi < yf ? yi : yf;
    yb = yi < yf ? yf : yi;
    if (xr > 79) xr = 79;
    if (yb > 59) yb = 59;
    if (xl < 80 && yt < 60)
      for (int yy = yt; yy <= yb; yy++)
        for (int xx = xl; xx <= xr; xx++)
          if (md != 1 || yy == yt || yy == yb || xx == xl || xx == xr)
            ref_px.push_back('{yy * 80 + xx, (md == 2 && ((xx ^ yy) & 1) == 1) ? c1 : c0});
  endtask
  task automatic run(input int xi, yi, xf, yf, md, c0, c1, rm, keep, abort_at, input int exp_done);
    int cnt, busy_bad;
    logic got;
    build(xi, yi, xf, yf, md, c0, c1);
    for (int k = 0; k < ref_px.size() && (keep < 0 || k < keep); k++) sb.push_back(ref_px[k]);
    if (exp_done == -2) exp_done = rm == 0 ? ref_px.size() + 2 : -1;
    rdy_mode = rm;
    @(posedge clk); #1;
    bus.xi = 16'(xi); bus.yi = 16'(yi); bus.xf = 16'(xf); bus.yf = 16'(yf);
    bus.mode = 2'(md); bus.color0 = 3'(c0); bus.color1 = 3'(c1);
    bus.start = 1; bus.abort = 0;
    cnt = 0; got = 0; busy_bad = 0;
    while (!got && cnt < 20000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        bus.xi = 16'($urandom_range(0, 300)); bus.yi = 16'($urandom_range(0, 300));
        bus.xf = 16'($urandom_range(0, 300)); bus.yf = 16'($urandom_range(0, 300));
        bus.mode = 2'($urandom_range(0, 3)); bus.color0 = 3'($urandom_range(0, 7));
        bus.color1 = 3'($urandom_range(0, 7));
      end
      bus.start = cnt == 2;
      bus.abort = cnt == abort_at;
      if (cnt == abort_at) rdy_mode = 3;
      if (!bus.busy) busy_bad++;
      got = bus.done;
    end
    bus.start = 0; bus.abort = 0;
    chk("done_seen", got, 1);
    if (exp_done >= 0) chk("done_cycle", cnt, exp_done);
    chk("busy_while_active", busy_bad, 0);
    @(posedge clk); #1;
    rdy_mode = 0;
    chk("done_pulse_width", bus.done, 0);
    chk("busy_fall", bus.busy, 0);
    chk("writes_outstanding", sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    bus.wr_ready = 0;
    forever begin
      @(posedge clk); #2;
      bus.wr_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) :
                     rdy_mode == 2 ? ~bus.wr_ready : 1'b0;
    end
  end
  initial begin
    logic stall_prev, abort_prev;
    int paddr, pdata;
    stall_prev = 0; abort_prev = 0; paddr = 0; pdata = 0;
    forever begin
      @(negedge clk);
      if (stall_prev && !abort_prev && !rst) begin
        chk("hold_enable", bus.wr_enable, 1);
        chk("hold_address", bus.wr_address, paddr);
        chk("hold_data", bus.wr_data, pdata);
      end
      if (bus.wr_enable === 1'b1 && bus.wr_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write", bus.wr_address, bus.wr_data);
        end else begin
          pix_t p;
          p = sb.pop_front();
          chk("write_address", bus.wr_address, p.addr);
          chk("write_data", bus.wr_data, p.data);
        end
      end
      stall_prev = bus.wr_enable === 1'b1 && bus.wr_ready === 1'b0;
      abort_prev = bus.abort;
      paddr = int'(bus.wr_address);
      pdata = int'(bus.wr_data);
    end
  end
  initial begin
    logic dn;
    n_cmp = 0; n_err = 0; rdy_mode = 0;
    rst = 1;
    bus.start = 0; bus.abort = 0; bus.xi = 0; bus.yi = 0; bus.xf = 0; bus.yf = 0;
    bus.mode = 0; bus.color0 = 0; bus.color1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_enable", bus.wr_enable, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_address", bus.wr_address, 0);
    chk("reset_data", bus.wr_data, 0);
    rst = 0;
    run(2, 1, 4, 2, 0, 2, 5, 0, -1, 0, 8);
    run(4, 2, 2, 1, 0, 2, 5, 0, -1, 0, 8);
    run(0, 0, 3, 3, 1, 4, 1, 0, -1, 0, 14);
    run(0, 0, 1, 1, 2, 1, 6, 2, -1, 0, -1);
    run(78, 58, 200, 100, 0, 7, 0, 0, -1, 0, 6);
    run(90, 3, 90, 10, 0, 3, 0, 0, -1, 0, 2);
    run(3, 70, 9, 80, 2, 3, 4, 0, -1, 0, 2);
    run(10, 10, 30, 20, 0, 5, 0, 0, 2, 4, 5);
    run(10, 10, 30, 20, 0, 5, 0, 0, 0, 1, 2);
    run(5, 5, 5, 5, 2, 1, 6, 0, -1, 0, 3);
    run(7, 6, 7, 2, 1, 3, 0, 1, -1, 0, -1);
    run(20, 9, 10, 12, 3, 6, 1, 0, -1, 0, -2);
    build(0, 0, 20, 5, 0, 3, 0);
    for (int k = 0; k < 4; k++) sb.push_back(ref_px[k]);
    rdy_mode = 0;
    @(posedge clk); #1;
    bus.xi = 0; bus.yi = 0; bus.xf = 20; bus.yf = 5; bus.mode = 0; bus.color0 = 3; bus.start = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus.start = 0;
      if (k == 5) rst = 1;
    end
    @(posedge clk); #1;
    rst = 0;
    chk("midreset_wr_enable", bus.wr_enable, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      dn = dn | bus.done;
    end
    chk("no_done_after_reset", dn, 0);
    chk("midreset_writes_outstanding", sb.size(), 0);
    sb.delete();
    run(2, 1, 4, 2, 0, 2, 5, 0, -1, 0, 8);
    for (int i = 0; i < 30; i++) begin
      int a, b, c, d, t;
      a = $urandom_range(0, 95);
      c = a + $urandom_range(0, 12);
      b = $urandom_range(0, 70);
      d = b + $urandom_range(0, 10);
      if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 65535);
      if ($urandom_range(0, 1) == 1) begin t = a; a = c; c = t; end
      if ($urandom_range(0, 1) == 1) begin t = b; b = d; d = t; end
      run(a, b, c, d, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), -1, 0, -2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
